// File: rtl/phase_monitor_pkg.sv
// Shared definitions for the two-phase clock monitor: FSM states and phase bit indices.
package phase_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    EXP_P1 = 2'd1,
    EXP_P0 = 2'd2
  } state_t;

  localparam int unsigned PHI0 = 0;
  localparam int unsigned PHI1 = 1;

endpackage

// File: rtl/phase_monitor_if.sv
// Phase strobe input, clear and monitor status bundle between prescaler side and monitor.
interface phase_monitor_if #(
  parameter int unsigned CNT_W = 4
);

  logic [1:0]       phase_in;
  logic             clr;
  logic             p0_rise;
  logic             p1_rise;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err_overlap;
  logic             err_order;
  logic             err_timeout;

  modport master (
    output phase_in, clr,
    input  p0_rise, p1_rise, period, period_valid, locked,
    input  err_overlap, err_order, err_timeout
  );

  modport slave (
    input  phase_in, clr,
    output p0_rise, p1_rise, period, period_valid, locked,
    output err_overlap, err_order, err_timeout
  );

endinterface

// File: rtl/phase_monitor_edge_detect.sv
// Two-stage sampler for one phase strobe with combinational and registered rise pulses.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_rise_q
);

  logic r_d1;
  logic r_d2;
  logic r_rise_q;
  logic w_rise;

  assign w_rise = r_d1 & ~r_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d1     <= 1'b0;
      r_d2     <= 1'b0;
      r_rise_q <= 1'b0;
    end else begin
      r_d1     <= i_d;
      r_d2     <= r_d1;
      r_rise_q <= w_rise;
    end
  end

  assign o_level  = r_d1;
  assign o_rise   = w_rise;
  assign o_rise_q = r_rise_q;

endmodule

// File: rtl/phase_monitor.sv
// Checks phi0/phi1 alternation, measures the phi0 period, tracks lock and raises sticky errors.
module phase_monitor
  import phase_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned LOCK_N = 4
) (
  input logic           clk,
  input logic           rst,
  phase_monitor_if.slave mon
);

  localparam int unsigned      LK_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LK_W-1:0]  LK_FULL = LK_W'(LOCK_N);
  localparam logic [LK_W-1:0]  LK_ONE  = LK_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic [LK_W-1:0]  r_lock_cnt;
  logic             r_locked;
  logic             r_first;
  logic             r_err_overlap;
  logic             r_err_order;
  logic             r_err_timeout;

  logic [1:0] w_d1;
  logic       w_r0;
  logic       w_r1;
  logic       w_p0q;
  logic       w_p1q;
  logic       w_ovl;
  logic       w_ord;
  logic       w_tmo;
  logic       w_err;
  logic       w_capture;
  logic       w_arm;

  edge_detect u_ed_phi0 (
    .clk      (clk),
    .rst      (rst),
    .i_d      (mon.phase_in[PHI0]),
    .o_level  (w_d1[PHI0]),
    .o_rise   (w_r0),
    .o_rise_q (w_p0q)
  );

  edge_detect u_ed_phi1 (
    .clk      (clk),
    .rst      (rst),
    .i_d      (mon.phase_in[PHI1]),
    .o_level  (w_d1[PHI1]),
    .o_rise   (w_r1),
    .o_rise_q (w_p1q)
  );

  // Only the highest-priority error of a cycle is flagged: overlap > order > timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_arm       = 1'b0;
    w_ord       = 1'b0;
    w_ovl       = w_d1[PHI0] & w_d1[PHI1];
    w_tmo       = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_r0) begin
          w_state_nxt = EXP_P1;
          w_arm       = 1'b1;
        end
      end
      EXP_P1: begin
        if (w_r0)      w_ord       = 1'b1;
        else if (w_r1) w_state_nxt = EXP_P0;
      end
      EXP_P0: begin
        if (w_r1) begin
          w_ord = 1'b1;
        end else if (w_r0) begin
          w_capture   = 1'b1;
          w_state_nxt = EXP_P1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
    if ((r_state != SEARCH) && (r_cnt == CNT_MAX)) w_tmo = 1'b1;
    w_ord = w_ord & ~w_ovl;
    w_tmo = w_tmo & ~w_ovl & ~w_ord;
    w_err = w_ovl | w_ord | w_tmo;
    if (w_err) begin
      w_state_nxt = SEARCH;
      w_capture   = 1'b0;
      w_arm       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= SEARCH;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_lock_cnt     <= '0;
      r_locked       <= 1'b0;
      r_first        <= 1'b0;
      r_err_overlap  <= 1'b0;
      r_err_order    <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_period_valid <= w_capture;

      if (w_r0)                 r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);

      if (w_capture) r_period <= r_cnt;

      if (w_arm)          r_first <= 1'b1;
      else if (w_capture) r_first <= 1'b0;

      if (w_err) begin
        r_lock_cnt <= '0;
      end else if (w_capture) begin
        if (r_first || (r_cnt != r_period)) r_lock_cnt <= LK_ONE;
        else if (r_lock_cnt != LK_FULL)     r_lock_cnt <= r_lock_cnt + LK_ONE;
      end

      // Lock is dropped at the error edge itself rather than waiting for lock_cnt.
      r_locked <= ~w_err & (r_lock_cnt == LK_FULL);

      r_err_overlap <= (r_err_overlap & ~mon.clr) | w_ovl;
      r_err_order   <= (r_err_order   & ~mon.clr) | w_ord;
      r_err_timeout <= (r_err_timeout & ~mon.clr) | w_tmo;
    end
  end

  assign mon.p0_rise      = w_p0q;
  assign mon.p1_rise      = w_p1q;
  assign mon.period       = r_period;
  assign mon.period_valid = r_period_valid;
  assign mon.locked       = r_locked;
  assign mon.err_overlap  = r_err_overlap;
  assign mon.err_order    = r_err_order;
  assign mon.err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor: nominal lock, overlap, order, timeout, period change, reset.
module tb_phase_monitor;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LOCK_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  phase_monitor_if #(.CNT_W(CNT_W)) bus ();

  phase_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p0_rise"},      32'(bus.p0_rise),      0);
    chk({tag, "_p1_rise"},      32'(bus.p1_rise),      0);
    chk({tag, "_period"},       32'(bus.period),       0);
    chk({tag, "_period_valid"}, 32'(bus.period_valid), 0);
    chk({tag, "_locked"},       32'(bus.locked),       0);
    chk({tag, "_err_overlap"},  32'(bus.err_overlap),  0);
    chk({tag, "_err_order"},    32'(bus.err_order),    0);
    chk({tag, "_err_timeout"},  32'(bus.err_timeout),  0);
  endtask

  task automatic step(input logic [1:0] ph);
    bus.phase_in = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic period4();
    step(2'b01); step(2'b00); step(2'b10); step(2'b00);
  endtask

  task automatic period6();
    step(2'b01); step(2'b00); step(2'b00); step(2'b10); step(2'b00); step(2'b00);
  endtask

  initial begin
    bus.phase_in = 2'b00;
    bus.clr      = 1'b0;

    // Reset state
    step(2'b00); step(2'b00);
    chk_zero("rst_hold");
    rst = 1'b0;
    step(2'b00);
    chk_zero("post_rst");

    // Nominal divide-by-4: lock one edge after the 5th phi0 rise
    repeat (4) period4();
    step(2'b01); step(2'b00);
    chk("nom_pv",       32'(bus.period_valid), 1);
    chk("nom_period",   32'(bus.period),       4);
    chk("nom_p0_rise",  32'(bus.p0_rise),      1);
    chk("nom_prelock",  32'(bus.locked),       0);
    step(2'b10);
    chk("nom_pv_pulse", 32'(bus.period_valid), 0);
    chk("nom_locked",   32'(bus.locked),       1);
    step(2'b00);
    chk("nom_p1_rise",  32'(bus.p1_rise),      1);
    chk("nom_no_ovl",   32'(bus.err_overlap),  0);
    chk("nom_no_ord",   32'(bus.err_order),    0);
    chk("nom_no_tmo",   32'(bus.err_timeout),  0);

    // Overlap while locked, with clr in the same cycle as the error
    step(2'b11);
    bus.clr = 1'b1;
    step(2'b00);
    bus.clr = 1'b0;
    chk("ovl_flag_clr_same", 32'(bus.err_overlap),  1);
    chk("ovl_unlock",        32'(bus.locked),       0);
    chk("ovl_no_capture",    32'(bus.period_valid), 0);
    step(2'b10); step(2'b00);
    repeat (4) period4();
    step(2'b01); step(2'b00);
    chk("ovl_relock_pre",    32'(bus.locked),       0);
    chk("ovl_relock_period", 32'(bus.period),       4);
    step(2'b10);
    chk("ovl_relock",        32'(bus.locked),       1);
    chk("ovl_sticky",        32'(bus.err_overlap),  1);
    step(2'b00);

    // Order: second phi0 without phi1
    step(2'b01); step(2'b00);
    chk("ord_capture",  32'(bus.period_valid), 1);
    chk("ord_hold_lock",32'(bus.locked),       1);
    step(2'b00); step(2'b00); step(2'b01); step(2'b00);
    chk("ord_flag",     32'(bus.err_order),    1);
    chk("ord_unlock",   32'(bus.locked),       0);
    chk("ord_no_pv",    32'(bus.period_valid), 0);
    bus.clr = 1'b1;
    step(2'b00);
    bus.clr = 1'b0;
    chk("ord_clr",      32'(bus.err_order),    0);
    chk("ord_clr_ovl",  32'(bus.err_overlap),  0);
    step(2'b10); step(2'b00); step(2'b01); step(2'b00);
    chk("search_no_capture", 32'(bus.period_valid), 0);
    chk("search_r1_ignored", 32'(bus.err_order),    0);

    // Timeout: phases stop after lock
    step(2'b10); step(2'b00);
    repeat (4) period4();
    chk("tmo_locked",      32'(bus.locked),      1);
    repeat (12) step(2'b00);
    chk("tmo_not_yet",     32'(bus.err_timeout), 0);
    chk("tmo_still_lock",  32'(bus.locked),      1);
    step(2'b00);
    chk("tmo_flag",        32'(bus.err_timeout), 1);
    chk("tmo_unlock",      32'(bus.locked),      0);
    chk("tmo_period_kept", 32'(bus.period),      4);

    // Period change from divide-by-4 to divide-by-6
    bus.clr = 1'b1;
    step(2'b00);
    bus.clr = 1'b0;
    chk("chg_clr_tmo", 32'(bus.err_timeout), 0);
    repeat (5) period4();
    chk("chg_locked4", 32'(bus.locked), 1);
    step(2'b01); step(2'b00);
    chk("chg_boundary_period", 32'(bus.period), 4);
    step(2'b00); step(2'b10); step(2'b00); step(2'b00);
    step(2'b01); step(2'b00);
    chk("chg_period6",    32'(bus.period),       6);
    chk("chg_pv",         32'(bus.period_valid), 1);
    chk("chg_lock_lag",   32'(bus.locked),       1);
    step(2'b00);
    chk("chg_unlock",     32'(bus.locked),       0);
    step(2'b10); step(2'b00); step(2'b00);
    repeat (2) period6();
    step(2'b01); step(2'b00);
    chk("chg_relock_pre", 32'(bus.locked),       0);
    chk("chg_period6_b",  32'(bus.period),       6);
    step(2'b00);
    chk("chg_relock",     32'(bus.locked),       1);
    step(2'b10); step(2'b00); step(2'b00);
    chk("chg_no_ovl",     32'(bus.err_overlap),  0);
    chk("chg_no_ord",     32'(bus.err_order),    0);
    chk("chg_no_tmo",     32'(bus.err_timeout),  0);

    // Reset between phi0 and phi1
    step(2'b01); step(2'b00);
    chk("rmid_pv",     32'(bus.period_valid), 1);
    chk("rmid_period", 32'(bus.period),       6);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    step(2'b10); step(2'b00);
    rst = 1'b0;
    step(2'b01); step(2'b00);
    chk("rmid_first_rise", 32'(bus.p0_rise),      1);
    chk("rmid_no_pv",      32'(bus.period_valid), 0);
    step(2'b10); step(2'b00);
    repeat (4) period4();
    chk("rmid_relock",     32'(bus.locked),       1);
    chk("rmid_period4",    32'(bus.period),       4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
